// File: rtl/null_src_pkt_scheduler_if.sv
// AXI-Stream payload bus between the null-source packet scheduler and the
// CHDR source port.
interface null_src_pkt_scheduler_if #(
    parameter int CHDR_W = 64
);
    logic [CHDR_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/null_src_pkt_scheduler.sv
// Null-source payload scheduler: bursts of fixed-length packets carrying a line-index pattern.
// Define NULL_SRC_SCHED_GAP_EN to build in the GAP state (idle cycles between packets).
module null_src_pkt_scheduler #(
    parameter int CHDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                   rfnoc_chdr_clk,
    input  logic                   rfnoc_chdr_rst,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic                   cfg_clear,
    input  logic [15:0]            cfg_lines_per_pkt,
    input  logic [CNT_W-1:0]       cfg_num_pkts,
    input  logic [15:0]            cfg_gap_cycles,
    null_src_pkt_scheduler_if.master m,
    output logic                   sts_busy,
    output logic                   sts_done,
    output logic [CNT_W-1:0]       sts_pkt_cnt,
    output logic [CNT_W-1:0]       sts_line_cnt
);
    localparam int REP = CHDR_W / 32;

`ifdef NULL_SRC_SCHED_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t           state_q, state_d;
    logic [15:0]      lpp_q, lpp_d;
    logic [CNT_W-1:0] npkts_q, npkts_d;
    logic [15:0]      idx_q, idx_d;
    logic [15:0]      line_q, line_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             stop_q, stop_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
`ifdef NULL_SRC_SCHED_GAP_EN
    logic [15:0]      gap_q, gap_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
`else
    logic             unused_gap;
    assign unused_gap = ^cfg_gap_cycles;
`endif

    logic             sending;
    logic             beat;
    logic             last_beat;
    logic [CNT_W-1:0] burst_inc;

    assign sending   = (state_q == SEND);
    assign beat      = sending && m.tready;
    assign last_beat = beat && (line_q == lpp_q);
    assign burst_inc = burst_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        lpp_d   = lpp_q;
        npkts_d = npkts_q;
        idx_d   = idx_q;
        line_d  = line_q;
        burst_d = burst_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
`ifdef NULL_SRC_SCHED_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // A simultaneous stop cancels the start.
                if (cfg_start && !cfg_stop) begin
                    lpp_d   = cfg_lines_per_pkt;
                    npkts_d = cfg_num_pkts;
`ifdef NULL_SRC_SCHED_GAP_EN
                    gap_d   = cfg_gap_cycles;
`endif
                    idx_d   = 16'd0;
                    line_d  = 16'd0;
                    burst_d = '0;
                    stop_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cfg_stop) stop_d = 1'b1;
                if (beat) begin
                    idx_d  = idx_q + 16'd1;
                    line_d = line_q + 16'd1;
                end
                if (last_beat) begin
                    line_d  = 16'd0;
                    burst_d = burst_inc;
                    if (stop_q || cfg_stop || (npkts_q != '0 && burst_inc == npkts_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end
`ifdef NULL_SRC_SCHED_GAP_EN
                    else if (gap_q != 16'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q - 16'd1;
                    end
`endif
                end
            end
`ifdef NULL_SRC_SCHED_GAP_EN
            GAP: begin
                if (cfg_stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == 16'd0) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        pkt_cnt_d  = cfg_clear ? '0 : pkt_cnt_q + CNT_W'(last_beat);
        line_cnt_d = cfg_clear ? '0 : line_cnt_q + CNT_W'(beat);
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            state_q    <= IDLE;
            lpp_q      <= '0;
            npkts_q    <= '0;
            idx_q      <= '0;
            line_q     <= '0;
            burst_q    <= '0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            line_cnt_q <= '0;
`ifdef NULL_SRC_SCHED_GAP_EN
            gap_q      <= '0;
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lpp_q      <= lpp_d;
            npkts_q    <= npkts_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
            burst_q    <= burst_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
            pkt_cnt_q  <= pkt_cnt_d;
            line_cnt_q <= line_cnt_d;
`ifdef NULL_SRC_SCHED_GAP_EN
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    // Outputs come straight from registers, so they hold while stalled.
    assign m.tvalid     = sending;
    assign m.tlast      = sending && (line_q == lpp_q);
    assign m.tdata      = sending ? {REP{~idx_q, idx_q}} : '0;
    assign sts_busy     = (state_q != IDLE);
    assign sts_done     = done_q;
    assign sts_pkt_cnt  = pkt_cnt_q;
    assign sts_line_cnt = line_cnt_q;
endmodule

// File: tb/tb_null_src_pkt_scheduler.sv
// Self-checking bench for null_src_pkt_scheduler: burst vectors plus stop/reset/clear corners.
// Gap expectations follow NULL_SRC_SCHED_GAP_EN exactly as the design does.
module tb_null_src_pkt_scheduler;
    localparam int CHDR_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_stop = 1'b0;
    logic              cfg_clear = 1'b0;
    logic [15:0]       cfg_lines_per_pkt = '0;
    logic [CNT_W-1:0]  cfg_num_pkts = '0;
    logic [15:0]       cfg_gap_cycles = '0;
    logic              sts_busy;
    logic              sts_done;
    logic [CNT_W-1:0]  sts_pkt_cnt;
    logic [CNT_W-1:0]  sts_line_cnt;

    null_src_pkt_scheduler_if #(.CHDR_W(CHDR_W)) axis ();

    null_src_pkt_scheduler #(.CHDR_W(CHDR_W), .CNT_W(CNT_W)) dut (
        .rfnoc_chdr_clk    (clk),
        .rfnoc_chdr_rst    (rst),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_clear         (cfg_clear),
        .cfg_lines_per_pkt (cfg_lines_per_pkt),
        .cfg_num_pkts      (cfg_num_pkts),
        .cfg_gap_cycles    (cfg_gap_cycles),
        .m                 (axis),
        .sts_busy          (sts_busy),
        .sts_done          (sts_done),
        .sts_pkt_cnt       (sts_pkt_cnt),
        .sts_line_cnt      (sts_line_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHDR_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int lpp;
        int npkts;
        int gap;
        bit rand_ready;
        bit clear;
        int exp_pkt;
        int exp_line;
    } vec_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    last_beat_cyc = 0;
    int    done_cyc = 0;
    int    done_cnt = 0;
    int    tlast_cyc = 0;
    int    exp_gap = 0;
    bit    have_tlast = 0;
    bit    check_gap = 0;
    bit    mon_en = 1;
    bit    rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: condition not reached within bound (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready is re-rolled 2 ns after every edge so it is stable for the monitor.
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on each beat, stall stability, gap length, done timing.
    initial begin
        beat_t             e;
        bit                prev_stall;
        logic [CHDR_W-1:0] prev_data;
        logic              prev_last;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (sts_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (mon_en && prev_stall) begin
                check("stall_tdata", 64'(axis.tdata), 64'(prev_data));
                check("stall_tlast", 64'(axis.tlast), 64'(prev_last));
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
            if (axis.tvalid && axis.tready) begin
                beats_seen++;
                last_beat_cyc = cyc;
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL extra_beat: got tdata %0h, expected no beat", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_tdata", 64'(axis.tdata), 64'(e.data));
                        check("beat_tlast", 64'(axis.tlast), 64'(e.last));
                    end
                    if (check_gap && have_tlast) begin
                        check("gap_len", 64'(cyc - tlast_cyc - 1), 64'(exp_gap));
                        have_tlast = 0;
                    end
                    if (axis.tlast) begin
                        have_tlast = 1;
                        tlast_cyc  = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_burst(input int lpp, input int npkts);
        beat_t       e;
        logic [15:0] k16;
        int          k;
        k = 0;
        for (int p = 0; p < npkts; p++) begin
            for (int l = 0; l <= lpp; l++) begin
                k16    = 16'(k);
                e.data = {(CHDR_W/32){~k16, k16}};
                e.last = (l == lpp);
                exp_q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_beats(input int target, input string name);
        int n;
        n = 0;
        while (beats_seen < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (beats_seen < target) fail_now(name);
        #2;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) fail_now(name);
        else check({name, "_latency"}, 64'(done_cyc - last_beat_cyc), 64'd1);
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        #2;
    endtask

    task automatic checkOutput(input string name, input int exp_pkt, input int exp_line);
        tick();
        check({name, "_busy"}, 64'(sts_busy), 64'd0);
        check({name, "_tvalid"}, 64'(axis.tvalid), 64'd0);
        check({name, "_pkt_cnt"}, 64'(sts_pkt_cnt), 64'(exp_pkt));
        check({name, "_line_cnt"}, 64'(sts_line_cnt), 64'(exp_line));
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        rand_ready = v.rand_ready;
        check_gap  = !v.rand_ready;
        have_tlast = 0;
`ifdef NULL_SRC_SCHED_GAP_EN
        exp_gap = v.gap;
`else
        exp_gap = 0;
`endif
        if (v.clear) begin
            cfg_clear = 1'b1;
            tick();
            cfg_clear = 1'b0;
        end
        cfg_lines_per_pkt = 16'(v.lpp);
        cfg_num_pkts      = CNT_W'(v.npkts);
        cfg_gap_cycles    = 16'(v.gap);
        push_burst(v.lpp, v.npkts);
        pulse_start();
        check({name, "_tvalid_after_start"}, 64'(axis.tvalid), 64'd1);
        wait_done(20000, name);
        rand_ready = 0;
        checkOutput(name, v.exp_pkt, v.exp_line);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   base;
        vecs[0] = '{lpp: 100, npkts: 5, gap: 0,  rand_ready: 0, clear: 1, exp_pkt: 5, exp_line: 505};
        vecs[1] = '{lpp: 100, npkts: 5, gap: 0,  rand_ready: 1, clear: 1, exp_pkt: 5, exp_line: 505};
        vecs[2] = '{lpp: 0,   npkts: 4, gap: 0,  rand_ready: 0, clear: 1, exp_pkt: 4, exp_line: 4};
        vecs[3] = '{lpp: 7,   npkts: 3, gap: 10, rand_ready: 0, clear: 1, exp_pkt: 3, exp_line: 24};
        vecs[4] = '{lpp: 3,   npkts: 2, gap: 2,  rand_ready: 1, clear: 0, exp_pkt: 5, exp_line: 32};

        repeat (3) tick();
        check("rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("rst_tlast", 64'(axis.tlast), 64'd0);
        check("rst_tdata", 64'(axis.tdata), 64'd0);
        check("rst_busy", 64'(sts_busy), 64'd0);
        check("rst_done", 64'(sts_done), 64'd0);
        check("rst_pkt_cnt", 64'(sts_pkt_cnt), 64'd0);
        check("rst_line_cnt", 64'(sts_line_cnt), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d: lpp=%0d npkts=%0d gap=%0d", i, vecs[i].lpp, vecs[i].npkts, vecs[i].gap);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] stop during packet 3 of an unbounded burst");
        check_gap = 0;
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        cfg_lines_per_pkt = 16'd100;
        cfg_num_pkts      = '0;
        cfg_gap_cycles    = 16'd0;
        push_burst(100, 3);
        base = beats_seen;
        pulse_start();
        wait_beats(base + 2 * 101 + 37, "stop_wait_line37");
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_done(500, "stop");
        checkOutput("stop", 3, 303);

        $display("[TB] start while busy, then start+stop together in idle");
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        cfg_lines_per_pkt = 16'd7;
        cfg_num_pkts      = CNT_W'(2);
        push_burst(7, 2);
        base = beats_seen;
        pulse_start();
        wait_beats(base + 5, "busy_wait");
        cfg_lines_per_pkt = 16'd1;
        cfg_num_pkts      = CNT_W'(9);
        pulse_start();
        wait_done(200, "busy_start");
        checkOutput("busy_start", 2, 16);
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        repeat (4) tick();
        check("start_stop_busy", 64'(sts_busy), 64'd0);
        check("start_stop_tvalid", 64'(axis.tvalid), 64'd0);

        $display("[TB] clear coinciding with a beat");
        mon_en = 0;
        cfg_lines_per_pkt = 16'd7;
        cfg_num_pkts      = '0;
        base = beats_seen;
        pulse_start();
        wait_beats(base + 10, "clear_wait");
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        check("clear_beat_line_cnt", 64'(sts_line_cnt), 64'd0);
        check("clear_beat_pkt_cnt", 64'(sts_pkt_cnt), 64'd0);
        check("clear_beat_busy", 64'(sts_busy), 64'd1);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_done(50, "clear_stop");
        tick();
        mon_en = 1;

        $display("[TB] reset at line 50, then restart from idx 0");
        mon_en = 0;
        cfg_lines_per_pkt = 16'd100;
        cfg_num_pkts      = '0;
        base = beats_seen;
        pulse_start();
        wait_beats(base + 50, "reset_wait");
        rst = 1'b1;
        tick();
        check("midrst_tvalid", 64'(axis.tvalid), 64'd0);
        check("midrst_tlast", 64'(axis.tlast), 64'd0);
        check("midrst_busy", 64'(sts_busy), 64'd0);
        check("midrst_pkt_cnt", 64'(sts_pkt_cnt), 64'd0);
        check("midrst_line_cnt", 64'(sts_line_cnt), 64'd0);
        rst = 1'b0;
        tick();
        mon_en = 1;
        v = '{lpp: 3, npkts: 1, gap: 0, rand_ready: 0, clear: 0, exp_pkt: 1, exp_line: 4};
        applyStimulus(v, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
